// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transmitter.
// The parity state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick on the last clock of every DIV-clock bit, pre_tick one clock earlier.
// clr restarts the period synchronously.
module uart_baud_gen #(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DIV - 1);
    localparam logic [CW-1:0] CntPreLast = CW'((DIV >= 2) ? (DIV - 2) : 0);

    if (DIV < 2) begin : g_bad_div
        $error("uart_baud_gen: DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick     = (cnt_q == CntLast);
    assign pre_tick = (cnt_q == CntPreLast);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, DATA_BITS payload LSB first, optional parity, stop bits.
// Parity support is compiled in with UART_TX_PARITY_EN; otherwise parity_mode is ignored.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] DataLast = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 pre_tick;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_bit_q, par_bit_d;
`else
    logic [1:0] unused_parity_mode;
    assign unused_parity_mode = parity_mode;
`endif

    // The timer is held clear while idle so every frame starts on a fresh bit period.
    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q == StIdle),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (tx_valid && ready_q) begin
                    state_d = StStart;
                    data_d  = tx_data;
                    bit_d   = '0;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                    par_bit_d = (parity_mode == PAR_ODD) ? ~(^tx_data) : (^tx_data);
`endif
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == DataLast) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        data_d = data_q >> 1;
                        bit_d  = bit_q + 1'b1;
                        tx_d   = data_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                // Registered pulse: raise it one clock early so it lands on the final clock.
                if (bit_q == StopLast && pre_tick) begin
                    done_d = 1'b1;
                end
                if (tick) begin
                    if (bit_q == StopLast) begin
                        state_d = StIdle;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end
`endif

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: an 8N1 and a 7-data/2-stop instance at DIV=16.
// Honours UART_TX_PARITY_EN in its reference model.
module tb_uart_tx_param;

    localparam int unsigned ClkHz = 1600;
    localparam int unsigned Baud  = 100;
    localparam int unsigned Div   = ClkHz / Baud;
`ifdef UART_TX_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    typedef struct {
        logic [15:0] bits;
        int          nbits;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v8, r8, tx8, busy8, done8;
    logic [7:0] d8;
    logic [1:0] pm8;
    logic       v7, r7, tx7, busy7, done7;
    logic [6:0] d7;
    logic [1:0] pm7;

    uart_tx_param #(
        .CLK_HZ(ClkHz), .BAUD(Baud), .DATA_BITS(8), .STOP_BITS(1)
    ) u_dut8 (
        .clk(clk), .rst(rst), .tx_valid(v8), .tx_ready(r8), .tx_data(d8),
        .parity_mode(pm8), .tx(tx8), .tx_busy(busy8), .tx_done(done8)
    );

    uart_tx_param #(
        .CLK_HZ(ClkHz), .BAUD(Baud), .DATA_BITS(7), .STOP_BITS(2)
    ) u_dut7 (
        .clk(clk), .rst(rst), .tx_valid(v7), .tx_ready(r7), .tx_data(d7),
        .parity_mode(pm7), .tx(tx7), .tx_busy(busy7), .tx_done(done7)
    );

    logic tx_w [2];
    logic rdy_w [2];
    logic busy_w [2];
    logic done_w [2];
    assign tx_w[0] = tx8;
    assign tx_w[1] = tx7;
    assign rdy_w[0] = r8;
    assign rdy_w[1] = r7;
    assign busy_w[0] = busy8;
    assign busy_w[1] = busy7;
    assign done_w[0] = done8;
    assign done_w[1] = done7;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Frame as a list of line levels: start, payload LSB first, optional parity, stops.
    function automatic exp_t model(input int unsigned d, input int dbits, input logic [1:0] m,
                                   input int sbits);
        exp_t e;
        int   n;
        int   ones;
        int   b;
        e.bits = '0;
        n = 0;
        ones = 0;
        e.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < dbits; i++) begin
            b = (d >> i) % 2;
            ones += b;
            e.bits[n] = (b == 1);
            n++;
        end
        if (ParEn && (m == 2'd1 || m == 2'd2)) begin
            e.bits[n] = (m == 2'd1) ? (ones % 2 == 1) : (ones % 2 == 0);
            n++;
        end
        for (int s = 0; s < sbits; s++) begin
            e.bits[n] = 1'b1;
            n++;
        end
        e.nbits = n;
        return e;
    endfunction

    task automatic mon(input int id);
        exp_t e;
        logic prev;
        int   n;
        int   bad;
        int   done_bad;
        int   hs_bad;
        bit   aborted;
        bit   have;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !tx_w[id]) begin
                have = 1'b0;
                if (id == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end else if (id == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    chk(1'b0, $sformatf("dut%0d_unexpected_frame", id), 1, 0);
                end else begin
                    n = e.nbits * Div;
                    aborted = 1'b0;
                    bad = 0;
                    done_bad = 0;
                    hs_bad = 0;
                    for (int c = 1; c <= n; c++) begin
                        if (c > 1) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx_w[id] !== e.bits[(c - 1) / Div]) bad++;
                        if (done_w[id] !== (c == n)) done_bad++;
                        if (rdy_w[id] !== 1'b0 || busy_w[id] !== 1'b1) hs_bad++;
                        if (c % Div == 0) begin
                            chk(bad == 0, $sformatf("dut%0d_bit%0d_samples_wrong", id,
                                (c - 1) / Div), bad, 0);
                            bad = 0;
                        end
                    end
                    if (!aborted) begin
                        chk(done_bad == 0, $sformatf("dut%0d_done_timing_errs", id), done_bad, 0);
                        chk(hs_bad == 0, $sformatf("dut%0d_ready_busy_errs", id), hs_bad, 0);
                        @(negedge clk);
                        if (!rst) begin
                            chk(tx_w[id] && rdy_w[id] && !busy_w[id] && !done_w[id],
                                $sformatf("dut%0d_gap_tx_rdy_busy_done", id),
                                {tx_w[id], rdy_w[id], busy_w[id], done_w[id]}, 4'b1100);
                        end
                    end
                end
            end
            prev = tx_w[id];
        end
    endtask

    initial mon(0);
    initial mon(1);

    task automatic drop_valid(input int id);
        if (id == 0) v8 = 1'b0;
        else v7 = 1'b0;
    endtask

    task automatic send(input int id, input int unsigned d, input logic [1:0] m, input bit keep,
                        output int t_acc);
        int   budget;
        exp_t e;
        budget = 0;
        t_acc = -1;
        @(negedge clk);
        if (id == 0) begin
            v8 = 1'b1;
            d8 = d[7:0];
            pm8 = m;
        end else begin
            v7 = 1'b1;
            d7 = d[6:0];
            pm7 = m;
        end
        while (!rdy_w[id] && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!rdy_w[id]) begin
            chk(1'b0, $sformatf("dut%0d_ready_timeout", id), 0, 1);
            drop_valid(id);
            return;
        end
        e = model(d, (id == 0) ? 8 : 7, m, (id == 0) ? 1 : 2);
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
        @(posedge clk);
        #1;
        t_acc = cyc;
        chk(!tx_w[id] && busy_w[id] && !rdy_w[id], $sformatf("dut%0d_accept_tx_busy_rdy", id),
            {tx_w[id], busy_w[id], rdy_w[id]}, 3'b010);
        if (!keep) drop_valid(id);
    endtask

    task automatic wait_idle(input int id);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!rdy_w[id] && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!rdy_w[id]) chk(1'b0, $sformatf("dut%0d_idle_timeout", id), 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int id;
        int unsigned d;
        logic [1:0] m;
        v8 = 1'b0; d8 = '0; pm8 = '0;
        v7 = 1'b0; d7 = '0; pm7 = '0;
        repeat (3) @(negedge clk);
        chk({tx8, r8, busy8, done8} == 4'b1100, "dut0_reset_state", {tx8, r8, busy8, done8}, 12);
        chk({tx7, r7, busy7, done7} == 4'b1100, "dut1_reset_state", {tx7, r7, busy7, done7}, 12);
        rst = 1'b0;

        // 8N1 0xA5, then parity modes on 0x07
        send(0, 32'hA5, 2'd0, 1'b0, t1);
        wait_idle(0);
        send(0, 32'h07, 2'd1, 1'b0, t1);
        wait_idle(0);
        send(0, 32'h07, 2'd2, 1'b0, t1);
        wait_idle(0);
        send(0, 32'h07, 2'd3, 1'b0, t1);
        wait_idle(0);

        // Back-to-back with tx_valid held high
        send(0, 32'h00, 2'd0, 1'b1, t1);
        send(0, 32'hFF, 2'd0, 1'b1, t2);
        v8 = 1'b0;
        chk(t2 - t1 == (1 + 8 + 0 + 1) * Div + 1, "b2b_accept_period", t2 - t1,
            (1 + 8 + 0 + 1) * Div + 1);
        wait_idle(0);

        // 7 data bits, 2 stop bits
        send(1, 32'h55, 2'd0, 1'b0, t1);
        wait_idle(1);

        // Inputs wiggled mid-frame must be ignored
        send(0, 32'h5A, 2'd0, 1'b0, t1);
        repeat (50) @(negedge clk);
        v8 = 1'b1; d8 = 8'hFF; pm8 = 2'd1;
        @(negedge clk);
        v8 = 1'b0;
        wait_idle(0);

        // Reset in the middle of the data bits, then a frame right after release
        send(0, 32'hC3, 2'd0, 1'b0, t1);
        repeat (Div * 3) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk({tx8, r8, busy8, done8} == 4'b1100, "midframe_reset_state",
            {tx8, r8, busy8, done8}, 12);
        v8 = 1'b1; d8 = 8'h3C; pm8 = 2'd0;
        q0.push_back(model(32'h3C, 8, 2'd0, 1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk(!tx8 && busy8, "accept_first_clock_after_rst", {tx8, busy8}, 1);
        @(negedge clk);
        v8 = 1'b0;
        wait_idle(0);

        // Randomised traffic across both instances
        for (int i = 0; i < 12; i++) begin
            id = $urandom_range(0, 1);
            d = $urandom;
            m = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send(id, d, m, 1'b0, t1);
        end
        wait_idle(0);
        wait_idle(1);
        repeat (Div) @(negedge clk);

        chk(q0.size() == 0, "dut0_frames_outstanding", q0.size(), 0);
        chk(q1.size() == 0, "dut1_frames_outstanding", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter: CLK_HZ, 50000000, system clock frequency in Hz.
REQ-002 Parameter: BAUD, 115200, line rate in bit/s; DIV = CLK_HZ/BAUD (integer division) SHALL be the clocks per bit.
REQ-003 Parameter: DATA_BITS, 8, payload bits per frame, legal 5..9.
REQ-004 Parameter: STOP_BITS, 1, stop bits per frame, legal 1 or 2.
REQ-005 Port: clk  input  1  system clock, rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous, active-high.
REQ-007 Port: tx_valid  input  1  frame request.
REQ-008 Port: tx_ready  output  1  block can accept a frame.
REQ-009 Port: tx_data  input  DATA_BITS  payload, LSB sent first.
REQ-010 Port: parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 Port: tx  output  1  serial line, idle high.
REQ-012 Port: tx_busy  output  1  high from acceptance through the last stop-bit clock.
REQ-013 Port: tx_done  output  1  one-cycle pulse on the final clock of the last stop bit.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP; all outputs SHALL be registered.
REQ-015 tx_ready SHALL be 1 only in IDLE; acceptance SHALL occur on a clock where tx_valid && tx_ready.
REQ-016 On acceptance: tx_data and parity_mode captured, baud counter cleared, state -> START, tx = 0 and tx_busy = 1 from the next cycle.
REQ-017 Every bit (start, data, parity, each stop) SHALL last exactly DIV clocks.
REQ-018 DATA SHALL shift out DATA_BITS bits, LSB first, then go to PARITY if parity is enabled, otherwise to STOP.
REQ-019 PARITY bit: even = XOR of payload; odd = inverted XOR of payload.
REQ-020 STOP SHALL drive tx = 1 for STOP_BITS*DIV clocks, pulse tx_done on its final clock, then go to IDLE.
REQ-021 Acceptance-to-acceptance period with tx_valid held high SHALL be NBITS*DIV+1 clocks, where NBITS = 1+DATA_BITS+P+STOP_BITS and P = 1 if parity is active, else 0.
REQ-022 tx_valid, tx_data and parity_mode SHALL be ignored while not in IDLE.
REQ-023 Widths: baud counter $clog2(DIV), bit counter $clog2(DATA_BITS+1); DIV<2, DATA_BITS outside 5..9 or STOP_BITS outside 1..2 SHALL cause an elaboration error.

Reset
REQ-024 rst SHALL force IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, all counters and the data register to 0, abandoning any frame in progress.
REQ-025 First acceptance SHALL be possible on the first clock after rst deasserts.

Configuration
REQ-026 With UART_TX_PARITY_EN defined, parity_mode SHALL be honoured per REQ-010/REQ-019.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, parity_mode SHALL remain as a port but be ignored, and P = 0.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum typedef and the parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-029 Sub-module uart_baud_gen SHALL provide the DIV-clock bit tick with a synchronous clear; uart_tx_param instantiates it once.

Verification (bench uses CLK_HZ=1600, BAUD=100, so DIV=16)
REQ-030 8N1, send 0xA5: tx = 0,1,0,1,0,0,1,0,1,1, each 16 clocks; tx_done on clock 160 after acceptance; tx_ready 0 throughout.
REQ-031 Parity enabled, 0x07: even mode -> parity bit 1, odd mode -> parity bit 0; 11-bit frame.
REQ-032 tx_valid held with 0x00 then 0xFF, 8N1: second acceptance exactly 161 clocks after the first; no glitch on tx between frames.
REQ-033 DATA_BITS=7, STOP_BITS=2, 0x55: 7 data bits, stop high for 32 clocks, tx_done on clock 160.
REQ-034 rst asserted mid-DATA: tx=1, tx_ready=1, tx_busy=0 immediately; a new 0x3C frame after release is sent correctly.
REQ-035 tx_data changed and tx_valid pulsed mid-frame: transmitted bits and timing unchanged.
